// File: rtl/jpeg_ctrl_pkg.sv
// Shared encodings for the JPEG session controller: opcodes, result codes, FSM states.
package jpeg_ctrl_pkg;

   localparam logic [3:0] OP_DECODE = 4'h1;
   localparam logic [3:0] OP_STATUS = 4'h2;

   typedef enum logic [2:0] {
      ERR_OK        = 3'd0,
      ERR_BAD_OP    = 3'd1,
      ERR_ZERO_LEN  = 3'd2,
      ERR_OVERFLOW  = 3'd3,
      ERR_TIMEOUT   = 3'd4,
      ERR_PREMATURE = 3'd5
   } err_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_START,
      ST_STREAM,
      ST_DRAIN,
      ST_STATUS,
      ST_REARM
   } state_t;

endpackage

// File: rtl/session_controller_if.sv
// Parser / decoder handshake bundle seen by the session controller.
interface session_controller_if #(
   parameter int COMMAND_WIDTH = 16
);
   logic [COMMAND_WIDTH-1:0] cmd_in;
   logic                     bit_in;
   logic                     bit_valid;
   logic                     dec_start;
   logic [7:0]               dec_byte;
   logic                     dec_byte_valid;
   logic                     dec_byte_ready;
   logic                     dec_done;
   logic                     parser_rearm;
   logic                     busy;
   logic                     session_done;
   logic [2:0]               err_code;
   logic                     status_valid;

   // Controller side
   modport slave (
      input  cmd_in, bit_in, bit_valid, dec_byte_ready, dec_done,
      output dec_start, dec_byte, dec_byte_valid, parser_rearm, busy,
             session_done, err_code, status_valid
   );

   // Parser/decoder side
   modport master (
      output cmd_in, bit_in, bit_valid, dec_byte_ready, dec_done,
      input  dec_start, dec_byte, dec_byte_valid, parser_rearm, busy,
             session_done, err_code, status_valid
   );
endinterface

// File: rtl/bit_byte_packer.sv
// MSB-first serial-to-byte packer with a one-deep holding register towards the decoder.
module bit_byte_packer (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear_i,
   input  logic       bit_en_i,
   input  logic       bit_i,
   input  logic       bit_valid_i,
   input  logic       ready_i,
   output logic [7:0] byte_o,
   output logic       valid_o,
   output logic       accept_o,
   output logic       overflow_o
);
   logic [7:0] shift_q, shift_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] hold_q, hold_d;
   logic       valid_q, valid_d;
   logic       take;
   logic       complete;
   logic [7:0] full_byte;

   assign take       = bit_en_i & bit_valid_i;
   assign full_byte  = {shift_q[6:0], bit_i};
   assign complete   = take & (cnt_q == 3'd7);
   assign accept_o   = valid_q & ready_i;
   assign overflow_o = complete & valid_q & ~ready_i;
   assign byte_o     = hold_q;
   assign valid_o    = valid_q;

   // Shift in bits; on the 8th bit move the byte to the holding register.
   // Acceptance and a new completion in one cycle simply reloads the register.
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      valid_d = valid_q;
      if (clear_i) begin
         shift_d = '0;
         cnt_d   = '0;
         hold_d  = '0;
         valid_d = 1'b0;
      end else begin
         if (take) begin
            shift_d = full_byte;
            cnt_d   = cnt_q + 3'd1;
         end
         if (overflow_o) begin
            valid_d = 1'b0;
         end else if (complete) begin
            hold_d  = full_byte;
            valid_d = 1'b1;
         end else if (accept_o) begin
            valid_d = 1'b0;
         end
      end
   end

   // Packer state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q <= '0;
         cnt_q   <= '0;
         hold_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: rtl/session_controller.sv
// Session FSM: command check, decoder start, byte streaming, drain watchdog, status reply.
module session_controller #(
   parameter int COMMAND_WIDTH = 16,
   parameter int TIMEOUT_WIDTH = 20
) (
   input logic                 clk,
   input logic                 rst,
   session_controller_if.slave bus
);
   import jpeg_ctrl_pkg::*;

   state_t                   state_q, state_d;
   logic [3:0]               op_q, op_d;
   logic [11:0]              len_q, len_d;
   logic [11:0]              byte_cnt_q, byte_cnt_d;
   logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
   err_t                     err_q, err_d;
   logic                     from_status_q, from_status_d;

   logic [COMMAND_WIDTH-1:0] cmd_w;
   logic                     bit_en;
   logic                     clear;
   logic                     accept;
   logic                     overflow;

   assign cmd_w  = bus.cmd_in;
   assign bit_en = (state_q == ST_IDLE)  || (state_q == ST_CHECK) ||
                   (state_q == ST_START) || (state_q == ST_STREAM);
   assign clear  = (state_q == ST_REARM);

   bit_byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (clear),
      .bit_en_i   (bit_en),
      .bit_i      (bus.bit_in),
      .bit_valid_i(bus.bit_valid),
      .ready_i    (bus.dec_byte_ready),
      .byte_o     (bus.dec_byte),
      .valid_o    (bus.dec_byte_valid),
      .accept_o   (accept),
      .overflow_o (overflow)
   );

   assign bus.dec_start    = (state_q == ST_START);
   assign bus.status_valid = (state_q == ST_STATUS);
   assign bus.parser_rearm = (state_q == ST_REARM);
   assign bus.session_done = (state_q == ST_REARM) && !from_status_q;
   assign bus.busy         = (state_q != ST_IDLE);
   assign bus.err_code     = err_q;

   // Next-state, counters and result code.
   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      len_d         = len_q;
      byte_cnt_d    = byte_cnt_q;
      wd_d          = wd_q;
      err_d         = err_q;
      from_status_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.bit_valid) begin
               op_d    = cmd_w[15:12];
               len_d   = cmd_w[11:0];
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (op_q == OP_DECODE) begin
               if (len_q == '0) begin
                  err_d   = ERR_ZERO_LEN;
                  state_d = ST_REARM;
               end else begin
                  state_d = ST_START;
               end
            end else if (op_q == OP_STATUS) begin
               state_d = ST_STATUS;
            end else begin
               err_d   = ERR_BAD_OP;
               state_d = ST_REARM;
            end
         end
         ST_START: begin
            err_d   = ERR_OK;
            state_d = ST_STREAM;
         end
         ST_STREAM: begin
            if (accept) byte_cnt_d = byte_cnt_q + 12'd1;
            // The counter is always below the length while streaming, so any
            // dec_done here is premature.
            if (overflow) begin
               err_d   = ERR_OVERFLOW;
               state_d = ST_REARM;
            end else if (bus.dec_done) begin
               err_d   = ERR_PREMATURE;
               state_d = ST_REARM;
            end else if (accept && (byte_cnt_d == len_q)) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (bus.dec_done) begin
               err_d   = ERR_OK;
               state_d = ST_REARM;
            end else if (wd_q == '1) begin
               err_d   = ERR_TIMEOUT;
               state_d = ST_REARM;
            end else begin
               wd_d = wd_q + TIMEOUT_WIDTH'(1);
            end
         end
         ST_STATUS: begin
            from_status_d = 1'b1;
            state_d       = ST_REARM;
         end
         ST_REARM: begin
            byte_cnt_d = '0;
            wd_d       = '0;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM and counter registers; reset overrides every other event.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         op_q          <= '0;
         len_q         <= '0;
         byte_cnt_q    <= '0;
         wd_q          <= '0;
         err_q         <= ERR_OK;
         from_status_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         len_q         <= len_d;
         byte_cnt_q    <= byte_cnt_d;
         wd_q          <= wd_d;
         err_q         <= err_d;
         from_status_q <= from_status_d;
      end
   end

endmodule

// File: tb/tb_session_controller.sv
// Self-checking bench for session_controller: command table, directed corner sequences,
// and randomized sessions against a result-code model.
module tb_session_controller;

   localparam int TW = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   session_controller_if #(.COMMAND_WIDTH(16)) bus ();

   session_controller #(
      .COMMAND_WIDTH(16),
      .TIMEOUT_WIDTH(TW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;
   int n_start = 0, n_done = 0, n_rearm = 0, n_status = 0;
   int status_err = 0, done_err = 0;
   int last_err = 0;
   logic [7:0] rx_q[$];
   logic [7:0] tx_q[$];
   logic ready_rand = 1'b0;
   logic ready_lvl  = 1'b1;
   logic rnd_bit    = 1'b1;

   typedef struct {
      logic [15:0] cmd;
      int          err;
      int          status;
   } vec_t;
   vec_t vecs[9];

   assign bus.dec_byte_ready = ready_rand ? rnd_bit : ready_lvl;

   // Random ready pattern for the decoder side
   always @(posedge clk) begin
      #1;
      rnd_bit = 1'($urandom_range(0, 1));
   end

   // Event monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (bus.dec_start) n_start <= n_start + 1;
      if (bus.session_done) begin
         n_done   <= n_done + 1;
         done_err <= int'(bus.err_code);
      end
      if (bus.parser_rearm) n_rearm <= n_rearm + 1;
      if (bus.status_valid) begin
         n_status   <= n_status + 1;
         status_err <= int'(bus.err_code);
      end
      if (bus.dec_byte_valid && bus.dec_byte_ready) rx_q.push_back(bus.dec_byte);
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   function automatic int model_err(input int op, input int len, input int prev);
      if (op == 1) return (len == 0) ? 2 : 0;
      if (op == 2) return prev;
      return 1;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic expire(input string name);
      checks++;
      errors++;
      $display("FAIL %s wait bound expired", name);
   endtask

   task automatic align();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      bus.bit_in    = b;
      bus.bit_valid = 1'b1;
      align();
      bus.bit_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap_max);
      for (int i = 7; i >= 0; i--) begin
         repeat ($urandom_range(0, gap_max)) align();
         send_bit(b[i]);
      end
   endtask

   task automatic wait_rx(input int target, input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (rx_q.size() >= target) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
         #1;
      end
      if (!ok) expire(name);
      align();
   endtask

   task automatic wait_idle(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         #1;
         if (!bus.busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) expire(name);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_dec_start"}, int'(bus.dec_start), 0);
      chk({tag, "_dec_byte"}, int'(bus.dec_byte), 0);
      chk({tag, "_dec_byte_valid"}, int'(bus.dec_byte_valid), 0);
      chk({tag, "_parser_rearm"}, int'(bus.parser_rearm), 0);
      chk({tag, "_busy"}, int'(bus.busy), 0);
      chk({tag, "_session_done"}, int'(bus.session_done), 0);
      chk({tag, "_err_code"}, int'(bus.err_code), 0);
      chk({tag, "_status_valid"}, int'(bus.status_valid), 0);
   endtask

   // One-bit session: everything except a nonzero-length decode
   task automatic run_single(input logic [15:0] cmd, input int exp_err, input int exp_status,
                             input string name);
      int s0, d0, r0, q0;
      align();
      s0 = n_start; d0 = n_done; r0 = n_rearm; q0 = n_status;
      bus.cmd_in = cmd;
      send_bit(1'($urandom_range(0, 1)));
      wait_idle({name, "_idle"});
      chk({name, "_err"}, int'(bus.err_code), exp_err);
      chk({name, "_starts"}, n_start - s0, 0);
      chk({name, "_rearms"}, n_rearm - r0, 1);
      chk({name, "_status_pulses"}, n_status - q0, exp_status);
      chk({name, "_done_pulses"}, n_done - d0, (exp_status != 0) ? 0 : 1);
      if (exp_status != 0) chk({name, "_status_err"}, status_err, exp_err);
      else                 chk({name, "_done_err"}, done_err, exp_err);
   endtask

   // Full decode session carrying the bytes in tx_q, dec_done after done_dly cycles
   task automatic run_decode(input logic [11:0] len, input int gap_max, input int done_dly,
                             input string name);
      int s0, d0, r0, rx0;
      align();
      s0 = n_start; d0 = n_done; r0 = n_rearm; rx0 = rx_q.size();
      bus.cmd_in = {4'h1, len};
      for (int k = 0; k < tx_q.size(); k++) begin
         send_byte(tx_q[k], gap_max);
         chk({name, "_lat_valid"}, int'(bus.dec_byte_valid), 1);
         chk({name, "_lat_byte"}, int'(bus.dec_byte), int'(tx_q[k]));
         wait_rx(rx0 + k + 1, {name, "_rx_wait"});
      end
      repeat (done_dly) align();
      bus.dec_done = 1'b1;
      align();
      bus.dec_done = 1'b0;
      wait_idle({name, "_idle"});
      chk({name, "_err"}, int'(bus.err_code), 0);
      chk({name, "_starts"}, n_start - s0, 1);
      chk({name, "_done_pulses"}, n_done - d0, 1);
      chk({name, "_rearms"}, n_rearm - r0, 1);
      chk({name, "_rx_count"}, rx_q.size() - rx0, tx_q.size());
      for (int k = 0; k < tx_q.size(); k++)
         if (rx0 + k < rx_q.size()) chk({name, "_rx_byte"}, int'(rx_q[rx0 + k]), int'(tx_q[k]));
   endtask

   task automatic run_random(input int n_sessions);
      int pick, len, exp;
      logic [3:0] op;
      logic [11:0] plen;
      for (int n = 0; n < n_sessions; n++) begin
         pick = $urandom_range(0, 9);
         if (pick <= 5) begin
            len = $urandom_range(1, 3);
            tx_q.delete();
            for (int k = 0; k < len; k++) tx_q.push_back(8'($urandom));
            ready_rand = 1'b1;
            run_decode(12'(len), 2, $urandom_range(0, 20), "rnd_decode");
            ready_rand = 1'b0;
            last_err = model_err(1, len, last_err);
         end else if (pick <= 7) begin
            plen = 12'($urandom);
            run_single({4'h2, plen}, model_err(2, int'(plen), last_err), 1, "rnd_status");
         end else begin
            if ($urandom_range(0, 1) == 0) begin
               op   = 4'h1;
               plen = '0;
            end else begin
               op   = 4'($urandom_range(0, 15));
               if (op == 4'h1 || op == 4'h2) op = op + 4'h5;
               plen = 12'($urandom);
            end
            exp = model_err(int'(op), int'(plen), last_err);
            run_single({op, plen}, exp, 0, "rnd_reject");
            last_err = exp;
         end
      end
   endtask

   initial begin
      int d0, r0, s0, rx0, cnt;
      bit seen;

      vecs[0] = '{cmd: 16'h2000, err: 0, status: 1};
      vecs[1] = '{cmd: 16'h7001, err: 1, status: 0};
      vecs[2] = '{cmd: 16'h2000, err: 1, status: 1};
      vecs[3] = '{cmd: 16'h1000, err: 2, status: 0};
      vecs[4] = '{cmd: 16'h2ABC, err: 2, status: 1};
      vecs[5] = '{cmd: 16'h0005, err: 1, status: 0};
      vecs[6] = '{cmd: 16'hF123, err: 1, status: 0};
      vecs[7] = '{cmd: 16'h3FFF, err: 1, status: 0};
      vecs[8] = '{cmd: 16'h2001, err: 1, status: 1};

      rst = 1'b1;
      bus.cmd_in    = '0;
      bus.bit_in    = 1'b0;
      bus.bit_valid = 1'b0;
      bus.dec_done  = 1'b0;
      repeat (3) align();
      check_outputs_zero("reset");
      rst = 1'b0;

      // Command table: rejects and status replies
      for (int v = 0; v < 9; v++)
         run_single(vecs[v].cmd, vecs[v].err, vecs[v].status, "table");

      // Three-byte decode, ready high, done 10 cycles after the last byte
      tx_q.delete();
      tx_q.push_back(8'hA5); tx_q.push_back(8'h3C); tx_q.push_back(8'hFF);
      run_decode(12'd3, 0, 10, "three_bytes");

      // Overflow: ready low while the second byte completes
      align();
      d0 = n_done; r0 = n_rearm; rx0 = rx_q.size();
      ready_lvl  = 1'b0;
      bus.cmd_in = 16'h1002;
      send_byte(8'h11, 0);
      chk("ovf_first_valid", int'(bus.dec_byte_valid), 1);
      chk("ovf_first_byte", int'(bus.dec_byte), 8'h11);
      send_byte(8'h22, 0);
      chk("ovf_valid_dropped", int'(bus.dec_byte_valid), 0);
      wait_idle("ovf_idle");
      chk("ovf_err", int'(bus.err_code), 3);
      chk("ovf_rx_count", rx_q.size() - rx0, 0);
      chk("ovf_done_pulses", n_done - d0, 1);
      chk("ovf_rearms", n_rearm - r0, 1);
      ready_lvl = 1'b1;

      // Status must report the overflow code unchanged
      run_single(16'h2000, 3, 1, "status_after_ovf");

      // Premature done after 2 of 4 bytes
      align();
      d0 = n_done; rx0 = rx_q.size();
      bus.cmd_in = 16'h1004;
      send_byte(8'h5A, 1);
      wait_rx(rx0 + 1, "early_rx1");
      send_byte(8'hC3, 1);
      wait_rx(rx0 + 2, "early_rx2");
      bus.dec_done = 1'b1;
      align();
      bus.dec_done = 1'b0;
      wait_idle("early_idle");
      chk("early_err", int'(bus.err_code), 5);
      chk("early_rx_count", rx_q.size() - rx0, 2);
      chk("early_done_pulses", n_done - d0, 1);

      // Watchdog expiry: exact cycle count from the last acceptance edge
      align();
      d0 = n_done; rx0 = rx_q.size();
      bus.cmd_in = 16'h1001;
      send_byte(8'h81, 0);
      wait_rx(rx0 + 1, "timeout_rx");
      cnt  = 0;
      seen = 1'b0;
      while (!seen && cnt < (1 << TW) + 50) begin
         @(negedge clk);
         #1;
         cnt++;
         if (n_done != d0) seen = 1'b1;
      end
      if (!seen) expire("timeout_wait");
      chk("timeout_cycles", cnt, (1 << TW) + 1);
      chk("timeout_err", int'(bus.err_code), 4);
      wait_idle("timeout_idle");

      // dec_done in the same cycle the watchdog saturates wins
      align();
      d0 = n_done; rx0 = rx_q.size();
      bus.cmd_in = 16'h1001;
      send_byte(8'h7E, 0);
      wait_rx(rx0 + 1, "tie_rx");
      repeat ((1 << TW) - 1) @(posedge clk);
      #1;
      bus.dec_done = 1'b1;
      align();
      bus.dec_done = 1'b0;
      wait_idle("tie_idle");
      chk("tie_err", int'(bus.err_code), 0);
      chk("tie_done_pulses", n_done - d0, 1);

      // Reset during STREAM, colliding with dec_done and bit_valid
      align();
      s0 = n_start; rx0 = rx_q.size();
      bus.cmd_in = 16'h1003;
      send_byte(8'h3D, 0);
      wait_rx(rx0 + 1, "rst_rx");
      send_bit(1'b1);
      send_bit(1'b0);
      d0 = n_done; r0 = n_rearm;
      rst           = 1'b1;
      bus.dec_done  = 1'b1;
      bus.bit_valid = 1'b1;
      align();
      rst           = 1'b0;
      bus.dec_done  = 1'b0;
      bus.bit_valid = 1'b0;
      check_outputs_zero("mid_reset");
      repeat (4) align();
      chk("mid_reset_rearms", n_rearm - r0, 0);
      chk("mid_reset_done_pulses", n_done - d0, 0);
      chk("mid_reset_starts", n_start - s0, 1);
      last_err = 0;
      tx_q.delete();
      tx_q.push_back(8'hC3);
      run_decode(12'd1, 1, 3, "post_reset");

      run_random(25);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
